dir_keypad_scanner: RTL and testbench
=====================================

# dir_keypad_scanner

Scans a 4x4 active-low button matrix and produces the debounced one-hot `direction` word that the snake game core samples on its move clock. It is the input-side counterpart of the LED-matrix scan: it drives one column low at a time, reads the rows back, debounces whole frames, and decodes the four direction keys. It sits between the board keypad pins and the game core's `direction` input, clocked on the raw board `clk`.

## Interface
- `SCAN_DIV`, default 50000: `clk` cycles per column slot. Must be >= 4.
- `DEBOUNCE`, default 4: number of consecutive identical frames required before the debounced map updates. Range 1..15.
- `clk`  input  1  board clock; all logic rises on posedge.
- `clear`  input  1  reset, asynchronous, active-high.
- `key_col`  output  4  column drive, active-low; exactly one bit low at any time.
- `key_row`  input  4  row sense, active-low with board pull-ups; asynchronous to `clk`.
- `direction`  output  4  one-hot direction: [0]=left, [1]=down, [2]=up, [3]=right.
- `key_event`  output  1  one-cycle pulse when any key goes from released to pressed in the debounced map.
- `key_code`  output  4  index `row*4+col` of the lowest-numbered newly pressed key; valid with `key_event` and held until the next event.

## Operation
- `key_row` passes through a 2-flop synchronizer before any use.
- Slot counter runs 0..SCAN_DIV-1. Column index `col` (0..3) advances when the counter wraps. `key_col = ~(4'b0001 << col)`.
- Rows are sampled on the last cycle of each slot (count == SCAN_DIV-1). Sampled value: `raw[row*4+col] = ~row_sync[row]`.
- Frame end is the last cycle of the column-3 slot. Compare the completed `raw` against the previous frame's `raw`:
  - equal: `stable_cnt` increments, saturating at DEBOUNCE-1.
  - different: `stable_cnt` is set to 0.
  - When the compare is equal and `stable_cnt` == DEBOUNCE-1 (or DEBOUNCE == 1), set `deb <= raw`.
- Press detection on each `deb` update: `new = raw & ~deb_old`. If `new` != 0, pulse `key_event` and load `key_code` with the lowest set index of `new`.
- Direction keys: up = key 1 (r0,c1), left = key 4 (r1,c0), right = key 6 (r1,c2), down = key 9 (r2,c1). All other keys reach only `key_code`.
- Direction decode from `deb`:
  - if exactly one direction key is pressed, that direction's bit is set;
  - if zero or two or more are pressed, the result is 4'b0000 (ambiguity is suppressed).
- The core rejects reversal. This block does not.

## Timing
- Reset values: `key_col` = 4'b1110, `direction` = 0, `key_event` = 0, `key_code` = 0. Slot counter, `col`, `raw`, `deb`, and `stable_cnt` are all 0.
- `clear` asserted mid-frame aborts the frame immediately. After release, scanning restarts at column 0, slot count 0.
- Frame length is 4*SCAN_DIV cycles.
- Press-to-output latency, for a press held steady from before a frame's column slot:
  - seen in `raw` at the end of that frame;
  - `deb`, `direction`, and `key_event` update at the end of frame N+DEBOUNCE-1 (counting that frame as N);
  - outputs are registered and visible on the cycle after that frame-end edge.
- Release follows the same latency. `key_event` never fires on release.
- Bounce shorter than one frame resets `stable_cnt` and delays the update; it never produces a glitch on `direction`.
- Slot counter and `col` wrap freely; no overflow states exist.

## Configuration
- `DIR_LATCH_EN` defined:
  - `direction` is sticky. It loads a new one-hot value only when the decode yields exactly one direction.
  - Releases and ambiguous states hold the last value. Only `clear` zeroes it.
  - This guarantees a short tap is not missed by the slow move clock.
- `DIR_LATCH_EN` undefined: `direction` follows the live decode of `deb`, including 0 when nothing is pressed.

## Test plan
Test parameters for all scenarios: SCAN_DIV=4, DEBOUNCE=3, frame = 16 cycles.
- Reset: assert `clear` mid-frame.
  - Required: `key_col`=4'b1110, `direction`=0, `key_event`=0 while asserted; column 0 resumes on release; `key_col` cycles 1110→1101→1011→0111 every 4 cycles.
- Clean press: hold r1 low while c2 is driven (right key) for 5 frames.
  - Required: `direction`=4'b1000; `key_event` pulses once with `key_code`=6; update lands exactly 1 cycle after the end of frame 3.
- Bounce: toggle r0 on c1 (up) every other frame for 6 frames, then hold steady.
  - Required: `direction` stays 0 during toggling; becomes 4'b0100 after 3 stable frames.
- Ambiguity: hold up and left together.
  - Required without macro: `direction`=0.
  - Required with `DIR_LATCH_EN`: `direction` keeps its prior value.
  - Required in both builds: `key_event` fires with `key_code`=1.
- Release:
  - Required with `DIR_LATCH_EN`: after right is held then released, `direction` stays 4'b1000 and no `key_event` occurs on release.
  - Required without macro: `direction`=0 three frames after release.

Source files
------------

// File: rtl/dir_keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, frame debounce, direction decode.
// Optional DIR_LATCH_EN: direction holds the last unambiguous one-hot value until clear.
module dir_keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       clear,
  output logic [3:0] key_col,
  input  logic [3:0] key_row,
  output logic [3:0] direction,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [3:0]    STABLE_MAX = 4'(DEBOUNCE - 1);

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   raw_q, raw_d, prev_q, prev_d, deb_q, deb_d;
  logic [3:0]    stable_cnt_q, stable_cnt_d;
  logic [3:0]    direction_q, direction_d;
  logic          key_event_q, key_event_d;
  logic [3:0]    key_code_q, key_code_d;

  logic [3:0]  col_onehot;
  logic [15:0] raw_frame;
  logic [15:0] new_keys;
  logic [3:0]  lowest;
  logic [3:0]  dir_keys;
  logic        slot_end, frame_end, same, dir_one_hot;

  assign col_onehot = 4'b0001 << col_q;

  // Current frame image with the row readback of the active column merged in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign raw_frame[4*gi +: 4] = (raw_q[4*gi +: 4] & ~col_onehot)
                                | ({4{~sync2_q[gi]}} & col_onehot);
  end

  always_comb begin
    sync1_d      = key_row;
    sync2_d      = sync1_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    raw_d        = raw_q;
    prev_d       = prev_q;
    deb_d        = deb_q;
    stable_cnt_d = stable_cnt_q;
    direction_d  = direction_q;
    key_event_d  = 1'b0;
    key_code_d   = key_code_q;
    same         = 1'b0;
    new_keys     = '0;
    lowest       = '0;

    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (col_q == 2'd3);

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    if (slot_end) begin
      col_d = col_q + 2'd1;
      raw_d = raw_frame;
    end

    if (frame_end) begin
      prev_d = raw_frame;
      same   = (raw_frame == prev_q);
      if (!same)
        stable_cnt_d = '0;
      else if (stable_cnt_q != STABLE_MAX)
        stable_cnt_d = stable_cnt_q + 4'd1;

      if (DEBOUNCE == 1 || (same && stable_cnt_d == STABLE_MAX)) begin
        deb_d    = raw_frame;
        new_keys = raw_frame & ~deb_q;
        for (int i = 15; i >= 0; i--) begin
          if (new_keys[i]) lowest = 4'(i);
        end
        if (new_keys != '0) begin
          key_event_d = 1'b1;
          key_code_d  = lowest;
        end
      end
    end

    // Bit order {right, up, down, left} = keys {6, 1, 9, 4}.
    dir_keys    = {deb_d[6], deb_d[1], deb_d[9], deb_d[4]};
    dir_one_hot = (dir_keys != 4'b0000) && ((dir_keys & (dir_keys - 4'd1)) == 4'b0000);
`ifdef DIR_LATCH_EN
    if (dir_one_hot) direction_d = dir_keys;
`else
    direction_d = dir_one_hot ? dir_keys : 4'b0000;
`endif
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1_q      <= 4'hF;
      sync2_q      <= 4'hF;
      cnt_q        <= '0;
      col_q        <= '0;
      raw_q        <= '0;
      prev_q       <= '0;
      deb_q        <= '0;
      stable_cnt_q <= '0;
      direction_q  <= '0;
      key_event_q  <= 1'b0;
      key_code_q   <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      deb_q        <= deb_d;
      stable_cnt_q <= stable_cnt_d;
      direction_q  <= direction_d;
      key_event_q  <= key_event_d;
      key_code_q   <= key_code_d;
    end
  end

  assign key_col   = ~col_onehot;
  assign direction = direction_q;
  assign key_event = key_event_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_dir_keypad_scanner.sv
// Randomized frame-level bench for dir_keypad_scanner with a behavioural keypad and debounce model.
module tb_dir_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] key_col, key_row, direction, key_code;
  logic       key_event;
  logic [15:0] keys = '0;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [15:0] m_last, m_deb;
  int          m_run;
  logic [3:0]  m_dir, m_code;
  logic        m_ev;
  int          k;
  int          frame_no = 0;

  // Direction key per output bit: left, down, up, right.
  int dir_key [4] = '{4, 9, 1, 6};

  always #5 clk = ~clk;

  dir_keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .clear     (clear),
    .key_col   (key_col),
    .key_row   (key_row),
    .direction (direction),
    .key_event (key_event),
    .key_code  (key_code)
  );

  // Physical matrix: a pressed key shorts its row to a column driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_col[c] && keys[r*4+c]) key_row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input logic [15:0] d);
    logic [3:0] v = '0;
    int n = 0;
    for (int b = 0; b < 4; b++)
      if (d[dir_key[b]]) begin
        v[b] = 1'b1;
        n++;
      end
    return (n == 1) ? v : 4'b0000;
  endfunction

  task automatic model_reset();
    m_last = '0;
    m_run  = 1;
    m_deb  = '0;
    m_dir  = '0;
    m_code = '0;
    m_ev   = 1'b0;
    k      = 0;
  endtask

  task automatic model_frame_end(input logic [15:0] raw);
    logic [15:0] nw;
    logic [3:0]  d;
    if (raw == m_last) m_run++;
    else begin
      m_run  = 1;
      m_last = raw;
    end
    m_ev = 1'b0;
    if (m_run >= DEBOUNCE) begin
      nw = raw & ~m_deb;
      if (nw != 0) begin
        m_ev = 1'b1;
        for (int i = 0; i < 16; i++)
          if (nw[i]) begin
            m_code = 4'(i);
            break;
          end
      end
      m_deb = raw;
    end
    d = decode(m_deb);
`ifdef DIR_LATCH_EN
    if (d != 4'b0000) m_dir = d;
`else
    m_dir = d;
`endif
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = 4'b0001 << ((k % FRAME) / SCAN_DIV);
    ec = ~ec;
    chk("key_col", {12'b0, key_col}, {12'b0, ec});
    chk("direction", {12'b0, direction}, {12'b0, m_dir});
    chk("key_event", {15'b0, key_event}, {15'b0, m_ev});
    chk("key_code", {12'b0, key_code}, {12'b0, m_code});
  endtask

  task automatic check_reset_state(input string ctx);
    chk({ctx, "_key_col"}, {12'b0, key_col}, 16'h000E);
    chk({ctx, "_direction"}, {12'b0, direction}, 16'h0000);
    chk({ctx, "_key_event"}, {15'b0, key_event}, 16'h0000);
    chk({ctx, "_key_code"}, {12'b0, key_code}, 16'h0000);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    check_reset_state("clear_async");
    repeat (3) begin
      @(posedge clk); #1;
      check_reset_state("clear_held");
    end
    clear = 1'b0;
    model_reset();
    $display("clear pulse applied mid-frame, scan restarts at column 0");
  endtask

  task automatic run_frame(input logic [15:0] kin, input int abort_at);
    keys = kin;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk); #1;
      k++;
      if (i == FRAME) model_frame_end(kin);
      else m_ev = 1'b0;
      check_outputs();
      if (i == abort_at) begin
        do_clear();
        return;
      end
    end
    frame_no++;
    $display("frame %0d keys=%h dir=%b ev=%b code=%0d", frame_no, kin, direction, key_event, key_code);
  endtask

  function automatic logic [15:0] pick_keys(input logic [15:0] prev);
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 16'(1) << dir_key[$urandom_range(0, 3)];
      2: v = (16'(1) << dir_key[$urandom_range(0, 3)]) | (16'(1) << dir_key[$urandom_range(0, 3)]);
      3: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
      4: v = 16'(1) << $urandom_range(0, 15);
      default: v = prev;
    endcase
    return v;
  endfunction

  initial begin
    logic [15:0] kr;
    int dur;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    clear = 1'b0;
    model_reset();

    // Clean press of right, then release.
    repeat (5) run_frame(16'h0040, 0);
    repeat (4) run_frame(16'h0000, 0);
    // Bouncing up key, then held steady.
    for (int j = 0; j < 6; j++) run_frame((j % 2 == 0) ? 16'h0002 : 16'h0000, 0);
    repeat (4) run_frame(16'h0002, 0);
    repeat (4) run_frame(16'h0000, 0);
    // Up and left together.
    repeat (4) run_frame(16'h0012, 0);
    repeat (4) run_frame(16'h0000, 0);
    // Right held then released.
    repeat (4) run_frame(16'h0040, 0);
    repeat (4) run_frame(16'h0000, 0);

    kr = '0;
    for (int e = 0; e < 50; e++) begin
      kr  = pick_keys(kr);
      dur = $urandom_range(1, 5);
      if (e == 25) run_frame(kr, $urandom_range(2, 14));
      for (int f = 0; f < dur; f++) run_frame(kr, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
